// File: rtl/gtx_prbs_err_mon_c160_pkg.sv
// gtx_prbs_err_mon_c160_pkg: lock-FSM state encoding and default thresholds/widths
package gtx_prbs_err_mon_c160_pkg;
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACQ    = 2'd1,
        S_LOCKED = 2'd2,
        S_LOST   = 2'd3
    } state_t;
    localparam int DEF_LOCK_CNT   = 8;
    localparam int DEF_UNLOCK_CNT = 4;
    localparam int DEF_ERR_W      = 16;
    localparam int DEF_WORD_W     = 32;
endpackage

// File: rtl/gtx_prbs_err_mon_c160_if.sv
// gtx_prbs_err_mon_c160_if: checker flags, clear/snapshot strobes and status/counter readout
// master drives CE3/STRT_MTCH/VALID/MATCH/CLR/SNAP; slave (the monitor) drives status and counters
interface gtx_prbs_err_mon_c160_if import gtx_prbs_err_mon_c160_pkg::*; #(
    parameter int ERR_W  = DEF_ERR_W,
    parameter int WORD_W = DEF_WORD_W
);
    logic              CE3;
    logic              STRT_MTCH;
    logic              VALID;
    logic              MATCH;
    logic              CLR;
    logic              SNAP;
    logic              LOCKED;
    logic              SYNC_LOST;
    logic              ERR_STB;
    logic [ERR_W-1:0]  ERR_CNT;
    logic [WORD_W-1:0] WORD_CNT;
    logic [ERR_W-1:0]  SNAP_ERR;
    logic [WORD_W-1:0] SNAP_WORD;
    modport master (
        output CE3, STRT_MTCH, VALID, MATCH, CLR, SNAP,
        input  LOCKED, SYNC_LOST, ERR_STB, ERR_CNT, WORD_CNT, SNAP_ERR, SNAP_WORD
    );
    modport slave (
        input  CE3, STRT_MTCH, VALID, MATCH, CLR, SNAP,
        output LOCKED, SYNC_LOST, ERR_STB, ERR_CNT, WORD_CNT, SNAP_ERR, SNAP_WORD
    );
endinterface

// File: rtl/gtx_prbs_err_mon_c160_sat_cnt.sv
// gtx_prbs_err_mon_c160_sat_cnt: saturating up-counter, sync clear has priority over ce
// ports: REC_CLK, RST_N (async, active low), ce (count), clr (sync clear), cnt (value)
module gtx_prbs_err_mon_c160_sat_cnt #(
    parameter int W = 16
) (
    input  logic         REC_CLK,
    input  logic         RST_N,
    input  logic         ce,
    input  logic         clr,
    output logic [W-1:0] cnt
);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clr ? '0 : (ce && !(&cnt_q)) ? cnt_q + W'(1) : cnt_q;
    always_ff @(posedge REC_CLK or negedge RST_N)
        if (!RST_N) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    assign cnt = cnt_q;
endmodule

// File: rtl/gtx_prbs_err_mon_c160.sv
// gtx_prbs_err_mon_c160: PRBS lock FSM with saturating word/error counters and snapshot
// ports: REC_CLK, RST_N (async, active low), bus (slave side of gtx_prbs_err_mon_c160_if)
module gtx_prbs_err_mon_c160 import gtx_prbs_err_mon_c160_pkg::*; #(
    parameter int LOCK_CNT   = DEF_LOCK_CNT,
    parameter int UNLOCK_CNT = DEF_UNLOCK_CNT,
    parameter int ERR_W      = DEF_ERR_W,
    parameter int WORD_W     = DEF_WORD_W
) (
    input logic                    REC_CLK,
    input logic                    RST_N,
    gtx_prbs_err_mon_c160_if.slave bus
);
    localparam int RUN_W  = $clog2(LOCK_CNT + 1);
    localparam int MISS_W = $clog2(UNLOCK_CNT + 1);
    state_t            state_q, state_d;
    logic [RUN_W-1:0]  run_q, run_d, run_nxt;
    logic [MISS_W-1:0] miss_q, miss_d, miss_nxt;
    logic              sync_lost_q, sync_lost_d;
    logic              err_stb_q, err_stb_d;
    logic [ERR_W-1:0]  snap_err_q, snap_err_d;
    logic [WORD_W-1:0] snap_word_q, snap_word_d;
    logic              word_inc, err_inc, lost_set;
    always_comb begin
        state_d  = state_q;
        run_d    = run_q;
        miss_d   = miss_q;
        word_inc = 1'b0;
        err_inc  = 1'b0;
        lost_set = 1'b0;
        run_nxt  = run_q + RUN_W'(1);
        miss_nxt = miss_q + MISS_W'(1);
        // a start pattern or a dropped VALID aborts whatever the link was doing
        if (bus.CE3) begin
            if (bus.STRT_MTCH || !bus.VALID) state_d = S_IDLE;
            else case (state_q)
                S_IDLE: begin
                    state_d = S_ACQ;
                    run_d   = '0;
                end
                S_ACQ: begin
                    run_d = bus.MATCH ? run_nxt : '0;
                    if (bus.MATCH && run_nxt == RUN_W'(LOCK_CNT)) begin
                        state_d = S_LOCKED;
                        miss_d  = '0;
                    end
                end
                S_LOCKED: begin
                    word_inc = 1'b1;
                    err_inc  = !bus.MATCH;
                    miss_d   = bus.MATCH ? '0 : miss_nxt;
                    if (!bus.MATCH && miss_nxt == MISS_W'(UNLOCK_CNT)) begin
                        state_d  = S_LOST;
                        lost_set = 1'b1;
                    end
                end
                default: begin
                    state_d = S_ACQ;
                    run_d   = '0;
                end
            endcase
        end
        sync_lost_d = !bus.CLR && (sync_lost_q || lost_set);
        err_stb_d   = err_inc && !bus.CLR;
        // snapshot takes the pre-update counter values, so SNAP+CLR loses nothing
        snap_err_d  = bus.SNAP ? bus.ERR_CNT : snap_err_q;
        snap_word_d = bus.SNAP ? bus.WORD_CNT : snap_word_q;
    end
    always_ff @(posedge REC_CLK or negedge RST_N)
        if (!RST_N) begin
            state_q     <= S_IDLE;
            run_q       <= '0;
            miss_q      <= '0;
            sync_lost_q <= 1'b0;
            err_stb_q   <= 1'b0;
            snap_err_q  <= '0;
            snap_word_q <= '0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            miss_q      <= miss_d;
            sync_lost_q <= sync_lost_d;
            err_stb_q   <= err_stb_d;
            snap_err_q  <= snap_err_d;
            snap_word_q <= snap_word_d;
        end
    gtx_prbs_err_mon_c160_sat_cnt #(.W(ERR_W)) u_err_cnt (
        .REC_CLK (REC_CLK),
        .RST_N   (RST_N),
        .ce      (err_inc),
        .clr     (bus.CLR),
        .cnt     (bus.ERR_CNT)
    );
    gtx_prbs_err_mon_c160_sat_cnt #(.W(WORD_W)) u_word_cnt (
        .REC_CLK (REC_CLK),
        .RST_N   (RST_N),
        .ce      (word_inc),
        .clr     (bus.CLR),
        .cnt     (bus.WORD_CNT)
    );
    assign bus.LOCKED    = state_q == S_LOCKED;
    assign bus.SYNC_LOST = sync_lost_q;
    assign bus.ERR_STB   = err_stb_q;
    assign bus.SNAP_ERR  = snap_err_q;
    assign bus.SNAP_WORD = snap_word_q;
endmodule

// File: tb/tb_gtx_prbs_err_mon_c160.sv
// tb_gtx_prbs_err_mon_c160: wide and narrow-counter monitors against a behavioural model
module tb_gtx_prbs_err_mon_c160;
    localparam int LOCK_CNT   = 8;
    localparam int UNLOCK_CNT = 4;
    logic REC_CLK = 1'b0;
    logic RST_N   = 1'b0;
    logic ce3 = 1'b0, strt = 1'b0, valid = 1'b0, match = 1'b0, clr = 1'b0, snap = 1'b0;
    bit   rnd_cs = 1'b0;
    int   n_chk = 0, n_err = 0;
    gtx_prbs_err_mon_c160_if #(.ERR_W(16), .WORD_W(32)) bus ();
    gtx_prbs_err_mon_c160_if #(.ERR_W(4), .WORD_W(6)) bus_s ();
    assign bus.CE3 = ce3;
    assign bus.STRT_MTCH = strt;
    assign bus.VALID = valid;
    assign bus.MATCH = match;
    assign bus.CLR = clr;
    assign bus.SNAP = snap;
    assign bus_s.CE3 = ce3;
    assign bus_s.STRT_MTCH = strt;
    assign bus_s.VALID = valid;
    assign bus_s.MATCH = match;
    assign bus_s.CLR = clr;
    assign bus_s.SNAP = snap;
    gtx_prbs_err_mon_c160 #(.LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT), .ERR_W(16), .WORD_W(32)) dut (
        .REC_CLK (REC_CLK),
        .RST_N   (RST_N),
        .bus     (bus.slave)
    );
    gtx_prbs_err_mon_c160 #(.LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT), .ERR_W(4), .WORD_W(6)) dut_s (
        .REC_CLK (REC_CLK),
        .RST_N   (RST_N),
        .bus     (bus_s.slave)
    );
    always #3 REC_CLK = ~REC_CLK;

    // model: link phase as a name, true (unsaturated) counts since reset/CLR
    string  m_st;
    int     m_run, m_miss;
    longint m_err, m_word, m_serr, m_sword;
    bit     m_sync, m_stb;

    function automatic longint sat(longint v, int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return v > mx ? mx : v;
    endfunction

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = "IDLE";
        m_run = 0;
        m_miss = 0;
        m_err = 0;
        m_word = 0;
        m_serr = 0;
        m_sword = 0;
        m_sync = 0;
        m_stb = 0;
    endtask

    task automatic model_step(bit ce, bit v, bit m, bit s, bit c, bit p);
        bit inc_w, inc_e;
        inc_w = 0;
        inc_e = 0;
        if (ce) begin
            if (s || !v) m_st = "IDLE";
            else if (m_st == "IDLE") begin
                m_st = "ACQ";
                m_run = 0;
            end else if (m_st == "ACQ") begin
                m_run = m ? m_run + 1 : 0;
                if (m_run == LOCK_CNT) begin
                    m_st = "LOCKED";
                    m_miss = 0;
                end
            end else if (m_st == "LOCKED") begin
                inc_w = 1;
                inc_e = !m;
                m_miss = m ? 0 : m_miss + 1;
                if (m_miss == UNLOCK_CNT) begin
                    m_st = "LOST";
                    m_sync = 1;
                end
            end else begin
                m_st = "ACQ";
                m_run = 0;
            end
        end
        if (p) begin
            m_serr = m_err;
            m_sword = m_word;
        end
        if (c) begin
            m_err = 0;
            m_word = 0;
            m_sync = 0;
        end else begin
            m_err += inc_e;
            m_word += inc_w;
        end
        m_stb = inc_e && !c;
    endtask

    task automatic compare_all();
        check("locked", bus.LOCKED, m_st == "LOCKED");
        check("sync_lost", bus.SYNC_LOST, m_sync);
        check("err_stb", bus.ERR_STB, m_stb);
        check("err_cnt", bus.ERR_CNT, sat(m_err, 16));
        check("word_cnt", bus.WORD_CNT, sat(m_word, 32));
        check("snap_err", bus.SNAP_ERR, sat(m_serr, 16));
        check("snap_word", bus.SNAP_WORD, sat(m_sword, 32));
        check("s_locked", bus_s.LOCKED, m_st == "LOCKED");
        check("s_sync_lost", bus_s.SYNC_LOST, m_sync);
        check("s_err_stb", bus_s.ERR_STB, m_stb);
        check("s_err_cnt", bus_s.ERR_CNT, sat(m_err, 4));
        check("s_word_cnt", bus_s.WORD_CNT, sat(m_word, 6));
        check("s_snap_err", bus_s.SNAP_ERR, sat(m_serr, 4));
        check("s_snap_word", bus_s.SNAP_WORD, sat(m_sword, 6));
    endtask

    task automatic tick(bit ce, bit v, bit m, bit s, bit c, bit p);
        @(negedge REC_CLK);
        ce3 = ce;
        valid = v;
        match = m;
        strt = s;
        clr = c;
        snap = p;
        model_step(ce, v, m, s, c, p);
        @(posedge REC_CLK);
        #1;
        compare_all();
    endtask

    // three off-phase clocks carry junk flags that must be ignored, then the word edge
    task automatic word(bit v, bit m, bit s);
        for (int i = 0; i < 3; i++)
            tick(1'b0, 1'($urandom), 1'($urandom), 1'($urandom),
                 rnd_cs && ($urandom % 16 == 0), rnd_cs && ($urandom % 16 == 0));
        tick(1'b1, v, m, s, rnd_cs && ($urandom % 16 == 0), rnd_cs && ($urandom % 16 == 0));
    endtask

    task automatic reset_mid();
        @(negedge REC_CLK);
        #1;
        RST_N = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge REC_CLK);
        ce3 = 1'b0;
        clr = 1'b0;
        snap = 1'b0;
        RST_N = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge REC_CLK);
        #1;
        compare_all();
        @(negedge REC_CLK);
        RST_N = 1'b1;
        for (int i = 0; i < 9; i++) word(1, 1, 0);
        for (int i = 1; i <= 100; i++) word(1, i != 10 && i != 50, 0);
        for (int i = 0; i < 4; i++) word(1, 0, 0);
        word(1, 1, 0);
        for (int i = 0; i < 8; i++) word(1, 1, 0);
        word(0, 0, 0);
        word(1, 1, 0);
        for (int i = 0; i < 7; i++) word(1, 1, 0);
        word(1, 1, 1);
        for (int i = 0; i < 9; i++) word(1, 1, 0);
        for (int i = 0; i < 20; i++) begin
            word(1, 0, 0);
            if (i % 3 == 2) word(1, 1, 0);
        end
        for (int i = 0; i < 3; i++) tick(0, 1, 1, 0, 0, 0);
        tick(1, 1, 0, 0, 1, 1);
        for (int i = 0; i < 4; i++) word(1, 1, 0);
        reset_mid();
        for (int i = 0; i < 5; i++) word(0, 1, 0);
        rnd_cs = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            int mp;
            mp = ((i / 250) % 2) ? 60 : 92;
            word(($urandom % 100) < 97, ($urandom % 100) < mp, ($urandom % 100) < 2);
            if (i == 900) reset_mid();
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
